flag_union_fifo: RTL and testbench
==================================

# flag_union_fifo

Parametrised FIFO for packed flag words that carry a union of two per-element views: a flags view (a, b, c) or a class view (a, 2-bit class). Each entry holds a ROWS x COLS array of 3-bit elements, a mode tag selecting the view, and a per-entry summary computed at enqueue. It sits between flag producers and consumers that need buffering with valid/ready back-pressure and a pre-reduced summary without re-scanning the array.

## Interface
- ROWS, default 4: outer array dimension (>=1).
- COLS, default 8: inner array dimension (>=1).
- DEPTH, default 4: FIFO entries (>=1, any integer).
- CNT_CLASS, default 2'd3: class code counted in class mode (a=0, b=1, c=2, d=3).
- Derived: N = ROWS*COLS; W = 3*N; CW = $clog2(N+1); LW = $clog2(DEPTH+1).
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  producer has a word.
- in_ready_o  out  1  FIFO can accept.
- in_mode_i  in  1  0 = flags view, 1 = class view.
- in_data_i  in  W  element k = r*COLS+c at bits [3k+2:3k].
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head.
- out_mode_o  out  1  head mode tag.
- out_data_o  out  W  head data.
- out_cnt_o  out  CW  head count summary.
- out_or_o  out  3  head reduction summary.
- level_o  out  LW  current occupancy.

## Operation
- Element bits: bit2 = a in both views; flags view bit1 = b, bit0 = c; class view bits[1:0] = class.
- Push when in_valid_i && in_ready_o; pop when out_valid_o && out_ready_i.
- Summary computed combinationally from in_data_i/in_mode_i at push, stored with the entry:
  - flags mode: cnt = number of elements with any bit set; or = bitwise OR of all elements.
  - class mode: cnt = number of elements with class == CNT_CLASS; or[2] = OR of all a bits; or[1:0] = maximum class across elements.
- cnt range 0..N; no saturation needed (CW holds N).
- Storage: circular buffer, write and read pointers wrap from DEPTH-1 to 0 (non-power-of-2 DEPTH must wrap correctly).
- in_ready_o = (level != DEPTH). No pass-through: full with simultaneous pop does not accept that cycle.
- out_valid_o = (level != 0). Pop while empty is ignored.
- While out_valid_o = 0, out_mode_o, out_data_o, out_cnt_o, out_or_o are forced to 0.
- Simultaneous push and pop (non-empty, non-full): level unchanged, both pointers advance.
- Head outputs remain stable while out_valid_o && !out_ready_i.

## Timing
- Reset (async assert, sync-safe deassert): level_o = 0, pointers = 0, out_valid_o = 0, in_ready_o = 1, all out_* data = 0. Reset mid-operation discards all entries immediately.
- Latency: word pushed at edge T into empty FIFO appears on out_* with out_valid_o = 1 after edge T (cycle T+1). No combinational in_* -> out_* path.
- level_o updates on the edge of the push/pop; in_ready_o deasserts in the cycle after the DEPTH-th push.
- Pop at edge T frees a slot; in_ready_o = 1 from cycle T+1.

## Test plan
- Reset, then push flags word all elements 3'b000 except element 5 = 3'b101 -> next cycle out_valid_o=1, out_cnt_o=1, out_or_o=3'b101, level_o=1.
- Class mode, element k class = k%4, a set only on element 0 (N=32) -> out_cnt_o=8, out_or_o=3'b111; with CNT_CLASS=0 cnt=8.
- Push DEPTH words with out_ready_i=0 -> in_ready_o=0, level_o=DEPTH; extra push with in_valid_i=1 dropped; drain yields words in order.
- Full FIFO, in_valid_i=1 and out_ready_i=1 -> one pop, no push, level_o=DEPTH-1; next cycle push accepted.
- DEPTH=3, 10 interleaved push/pop with stalls -> data, mode, summaries in order across pointer wrap; outputs 0 whenever empty.
- Assert rst_ni low with 2 entries queued -> out_valid_o=0, level_o=0, in_ready_o=1 immediately; post-reset push behaves as first test.

Source files
------------

// File: rtl/flag_union_fifo.sv
// flag_union_fifo
//   Circular-buffer FIFO for packed ROWS x COLS arrays of 3-bit flag elements.
//   Each entry carries a mode tag (0 = flags view {a,b,c}, 1 = class view
//   {a, class[1:0]}) and a summary computed at enqueue time, so consumers
//   never need to rescan the array.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   producer has a word
//   in_ready_o   FIFO can accept (level != DEPTH, no pass-through when full)
//   in_mode_i    view selector of the incoming word
//   in_data_i    element k = r*COLS+c at bits [3k+2:3k]
//   out_valid_o  head entry valid (level != 0)
//   out_ready_i  consumer accepts head
//   out_mode_o   head mode tag        (0 while empty)
//   out_data_o   head data            (0 while empty)
//   out_cnt_o    head count summary   (0 while empty)
//   out_or_o     head reduction       (0 while empty)
//   level_o      current occupancy
module flag_union_fifo #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 8,
  parameter int unsigned DEPTH     = 4,
  parameter logic [1:0]  CNT_CLASS = 2'd3,
  localparam int unsigned N  = ROWS * COLS,
  localparam int unsigned W  = 3 * N,
  localparam int unsigned CW = $clog2(N + 1),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_mode_i,
  input  logic [W-1:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_mode_o,
  output logic [W-1:0]  out_data_o,
  output logic [CW-1:0] out_cnt_o,
  output logic [2:0]    out_or_o,
  output logic [LW-1:0] level_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_data [DEPTH];
  logic          mem_mode [DEPTH];
  logic [CW-1:0] mem_cnt  [DEPTH];
  logic [2:0]    mem_or   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic          push;
  logic          pop;
  logic [CW-1:0] push_cnt;
  logic [2:0]    push_or;
  logic [2:0]    elem;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths cycle correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready_o  = (level != LW'(DEPTH));
  assign out_valid_o = (level != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign level_o     = level;

  // Summary of the incoming word; in class view or[1:0] tracks the max class.
  always_comb begin
    push_cnt = '0;
    push_or  = '0;
    elem     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      elem = in_data_i[3*k +: 3];
      if (in_mode_i) begin
        if (elem[1:0] == CNT_CLASS) push_cnt = push_cnt + CW'(1);
        push_or[2] = push_or[2] | elem[2];
        if (elem[1:0] > push_or[1:0]) push_or[1:0] = elem[1:0];
      end else begin
        if (elem != 3'b000) push_cnt = push_cnt + CW'(1);
        push_or = push_or | elem;
      end
    end
  end

  // Storage is not reset: reset empties the FIFO by clearing level/pointers,
  // and the head outputs are gated by out_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data_i;
      mem_mode[wr_ptr] <= in_mode_i;
      mem_cnt[wr_ptr]  <= push_cnt;
      mem_or[wr_ptr]   <= push_or;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    out_mode_o = 1'b0;
    out_data_o = '0;
    out_cnt_o  = '0;
    out_or_o   = '0;
    if (out_valid_o) begin
      out_mode_o = mem_mode[rd_ptr];
      out_data_o = mem_data[rd_ptr];
      out_cnt_o  = mem_cnt[rd_ptr];
      out_or_o   = mem_or[rd_ptr];
    end
  end

endmodule

// File: tb/tb_flag_union_fifo.sv
// Bench for flag_union_fifo: two instances share the input side
//   u_dut_a : DEPTH=3, CNT_CLASS=3 (non-power-of-two wrap)
//   u_dut_b : DEPTH=4, CNT_CLASS=0
// Each is compared every cycle against a queue-based reference model.
module tb_flag_union_fifo;

  localparam int N  = 32;
  localparam int W  = 96;
  localparam int CW = 6;
  localparam int DA = 3;
  localparam int DB = 4;

  typedef struct {
    logic          mode;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic [2:0]    orv;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_mode;
  logic [W-1:0]  in_data;
  logic          out_ready;

  logic          rdy_a, val_a, mode_a;
  logic [W-1:0]  data_a;
  logic [CW-1:0] cnt_a;
  logic [2:0]    or_a;
  logic [1:0]    lvl_a;

  logic          rdy_b, val_b, mode_b;
  logic [W-1:0]  data_b;
  logic [CW-1:0] cnt_b;
  logic [2:0]    or_b;
  logic [2:0]    lvl_b;

  ent_t q_a[$];
  ent_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  flag_union_fifo #(.ROWS(4), .COLS(8), .DEPTH(DA), .CNT_CLASS(2'd3)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_a), .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(val_a), .out_ready_i(out_ready), .out_mode_o(mode_a),
    .out_data_o(data_a), .out_cnt_o(cnt_a), .out_or_o(or_a), .level_o(lvl_a)
  );

  flag_union_fifo #(.ROWS(4), .COLS(8), .DEPTH(DB), .CNT_CLASS(2'd0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(rdy_b), .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(val_b), .out_ready_i(out_ready), .out_mode_o(mode_b),
    .out_data_o(data_b), .out_cnt_o(cnt_b), .out_or_o(or_b), .level_o(lvl_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference summary straight from the element rules.
  function automatic ent_t make_ent(input logic mode, input logic [W-1:0] d, input logic [1:0] tgt);
    ent_t e;
    int   cnt = 0;
    int   max_cls = 0;
    logic any_a = 1'b0;
    logic [2:0] acc = 3'b000;
    logic [2:0] el;
    for (int k = 0; k < N; k++) begin
      el = d[3*k +: 3];
      if (mode) begin
        if (el[1:0] == tgt) cnt++;
        any_a = any_a | el[2];
        if (int'(el[1:0]) > max_cls) max_cls = int'(el[1:0]);
      end else begin
        if (el != 3'b000) cnt++;
        acc = acc | el;
      end
    end
    e.mode = mode;
    e.data = d;
    e.cnt  = CW'(cnt);
    e.orv  = mode ? {any_a, 2'(max_cls)} : acc;
    return e;
  endfunction

  task automatic check_all();
    ent_t h;
    check("a_valid", val_a, q_a.size() != 0);
    check("a_ready", rdy_a, q_a.size() != DA);
    check("a_level", lvl_a, q_a.size());
    h = '{mode: 1'b0, data: '0, cnt: '0, orv: '0};
    if (q_a.size() != 0) h = q_a[0];
    check("a_mode", mode_a, h.mode);
    check("a_data", data_a, h.data);
    check("a_cnt",  cnt_a,  h.cnt);
    check("a_or",   or_a,   h.orv);
    check("b_valid", val_b, q_b.size() != 0);
    check("b_ready", rdy_b, q_b.size() != DB);
    check("b_level", lvl_b, q_b.size());
    h = '{mode: 1'b0, data: '0, cnt: '0, orv: '0};
    if (q_b.size() != 0) h = q_b[0];
    check("b_mode", mode_b, h.mode);
    check("b_data", data_b, h.data);
    check("b_cnt",  cnt_b,  h.cnt);
    check("b_or",   or_b,   h.orv);
  endtask

  // One clock: model decides accept/pop from pre-edge occupancy, then checks.
  task automatic step();
    bit push_a, pop_a, push_b, pop_b;
    ent_t ea, eb;
    push_a = in_valid && (q_a.size() != DA);
    pop_a  = out_ready && (q_a.size() != 0);
    push_b = in_valid && (q_b.size() != DB);
    pop_b  = out_ready && (q_b.size() != 0);
    ea = make_ent(in_mode, in_data, 2'd3);
    eb = make_ent(in_mode, in_data, 2'd0);
    @(posedge clk);
    if (pop_a)  void'(q_a.pop_front());
    if (push_a) q_a.push_back(ea);
    if (pop_b)  void'(q_b.pop_front());
    if (push_b) q_b.push_back(eb);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    d = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: d = d & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
      1: d = '0;
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [W-1:0] elem5_word();
    logic [W-1:0] d = '0;
    d[17:15] = 3'b101;
    return d;
  endfunction

  function automatic logic [W-1:0] class_word();
    logic [W-1:0] d = '0;
    for (int k = 0; k < N; k++) d[3*k +: 3] = {(k == 0), 2'(k % 4)};
    return d;
  endfunction

  task automatic first_push_test();
    in_valid = 1'b1; in_mode = 1'b0; in_data = elem5_word(); out_ready = 1'b0;
    step();
    check("t1_valid", val_a, 1'b1);
    check("t1_cnt",   cnt_a, 6'd1);
    check("t1_or",    or_a,  3'b101);
    check("t1_level", lvl_a, 2'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    first_push_test();

    // Class-view word: classes k%4 -> 8 of each; a only on element 0.
    in_valid = 1'b1; in_mode = 1'b1; in_data = class_word(); out_ready = 1'b0;
    step();
    check("t2_cnt_cls3", cnt_a, 6'd8);
    check("t2_or",       or_a,  3'b111);
    check("t2_cnt_cls0", cnt_b, 6'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Fill both with consumer stalled; extra pushes must be dropped.
    out_ready = 1'b0;
    for (int i = 0; i < DB + 1; i++) begin
      in_valid = 1'b1; in_mode = 1'($urandom); in_data = rand_data();
      step();
    end
    check("t3_full_a", rdy_a, 1'b0);
    check("t3_lvl_b",  lvl_b, 3'd4);

    // Full with push and pop together: only the pop happens.
    in_valid = 1'b1; out_ready = 1'b1; in_data = rand_data();
    step();
    check("t4_lvl_a", lvl_a, 2'd2);
    check("t4_lvl_b", lvl_b, 3'd3);
    out_ready = 1'b0; in_data = rand_data();
    step();
    check("t4_push_a", lvl_a, 2'd3);

    // Drain in order.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DB; i++) step();

    // Randomized interleaving with stalls, crossing pointer wrap many times.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_mode   = 1'($urandom);
      in_data   = rand_data();
      step();
    end

    // Reset with two entries queued.
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DB; i++) step();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_mode = 1'($urandom); in_data = rand_data();
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q_a.delete();
    q_b.delete();
    check("rst_valid_a", val_a, 1'b0);
    check("rst_level_a", lvl_a, 2'd0);
    check("rst_ready_a", rdy_a, 1'b1);
    check("rst_data_a",  data_a, '0);
    check_all();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();
    first_push_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
